uart_rx_buf_ctrl: RTL

- Sequencer for the 4-entry UART receive buffer, which has a single address port (RD, WR, rpaddr, dataIn, dataOut).
- Owns write/read pointers and occupancy, and writes each received byte from the RX deserializer into the buffer.
- Serves host read requests and shares the one address port between writer and reader, with writes taking priority.
- Sits between the UART RX shifter, BUFFER_R and the host register interface.

---
 rtl/uart_rxc_pkg.sv | 14 +
 rtl/uart_rxc_ptr.sv | 65 ++++++
 rtl/uart_rx_buf_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rxc_pkg.sv
// Shared definitions for the UART receive-buffer sequencer.
// Holds the FSM state encoding and the default data width and buffer depth.
package uart_rxc_pkg;

    localparam int unsigned DefBitwidth = 8;
    localparam int unsigned DefDepth    = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2
    } rxc_state_e;

endpackage

// File: rtl/uart_rxc_ptr.sv
// Write/read pointer and occupancy tracker for the UART receive buffer.
// Ports:
//   Clk, Rst         clock, synchronous active-high reset
//   inc_wr, inc_rd   advance write / read pointer (one entry added / removed)
//   wr_ptr, rd_ptr   current buffer addresses, wrap modulo DEPTH
//   count            occupancy 0..DEPTH
//   full, empty      decoded from count, not from pointer comparison
module uart_rxc_ptr
    import uart_rxc_pkg::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned ADDR_W = $clog2(DefDepth)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              inc_wr,
    input  logic              inc_rd,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (inc_wr) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (inc_rd) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (inc_wr && !inc_rd) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (!inc_wr && inc_rd) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == (ADDR_W + 1)'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/uart_rx_buf_ctrl.sv
// Sequencer for the single-port UART receive buffer.
// Writes each received byte into the buffer and serves host reads, sharing the
// one address port; a write always wins the port on a given edge.
// Optional feature: define UART_RXC_IRQ_EN to add the registered irq output
// (count >= IRQ_LEVEL or overrun).
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   rx_valid, rx_data   received byte strobe and data
//   rd_req              host read request (level, sampled in idle)
//   rd_valid, rd_data   one-cycle read strobe, last byte read
//   buf_wr, buf_rd, buf_addr, buf_din, buf_dout   buffer port
//   count, empty, full  occupancy and flags
//   overrun, clr_ovr    sticky dropped-byte flag and its clear
//   irq                 interrupt (UART_RXC_IRQ_EN only)
module uart_rx_buf_ctrl
    import uart_rxc_pkg::*;
#(
    parameter int unsigned BITWIDTH = DefBitwidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned ADDR_W   = 2
`ifdef UART_RXC_IRQ_EN
    ,
    parameter int unsigned IRQ_LEVEL = 2
`endif
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                rx_valid,
    input  logic [BITWIDTH-1:0] rx_data,
    input  logic                rd_req,
    output logic                rd_valid,
    output logic [BITWIDTH-1:0] rd_data,
    output logic                buf_wr,
    output logic                buf_rd,
    output logic [ADDR_W-1:0]   buf_addr,
    output logic [BITWIDTH-1:0] buf_din,
    input  logic [BITWIDTH-1:0] buf_dout,
    output logic [ADDR_W:0]     count,
    output logic                empty,
    output logic                full,
    output logic                overrun,
    input  logic                clr_ovr
`ifdef UART_RXC_IRQ_EN
    ,
    output logic                irq
`endif
);

    rxc_state_e state_q, state_d;

    logic                wr_issue;
    logic                rd_start;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count_w;
    logic                full_w;
    logic                empty_w;

    logic                buf_wr_q, buf_wr_d;
    logic                buf_rd_q, buf_rd_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [BITWIDTH-1:0] buf_din_q, buf_din_d;
    logic                rd_valid_q, rd_valid_d;
    logic [BITWIDTH-1:0] rd_data_q, rd_data_d;
    logic                overrun_q, overrun_d;

    assign wr_issue = rx_valid && !full_w;
    // A read may only start from idle on an edge the writer does not claim.
    assign rd_start = (state_q == StIdle) && rd_req && !empty_w && !wr_issue;

    uart_rxc_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .Clk    (Clk),
        .Rst    (Rst),
        .inc_wr (wr_issue),
        .inc_rd (rd_start),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .count  (count_w),
        .full   (full_w),
        .empty  (empty_w)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (rd_start) state_d = StIssue;
            StIssue:   state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output next-values; all of them are registered below.
    always_comb begin
        buf_wr_d   = wr_issue;
        buf_rd_d   = rd_start;
        buf_addr_d = buf_addr_q;
        buf_din_d  = buf_din_q;
        if (wr_issue) begin
            buf_addr_d = wr_ptr;
            buf_din_d  = rx_data;
        end else if (rd_start) begin
            buf_addr_d = rd_ptr;
        end
        // The buffer registered dataOut on the previous edge; take it now.
        rd_valid_d = (state_q == StCapture);
        rd_data_d  = rd_valid_d ? buf_dout : rd_data_q;
        overrun_d  = overrun_q;
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (rx_valid && full_w) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            buf_wr_q   <= 1'b0;
            buf_rd_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
            buf_addr_q <= buf_addr_d;
            buf_din_q  <= buf_din_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign buf_wr   = buf_wr_q;
    assign buf_rd   = buf_rd_q;
    assign buf_addr = buf_addr_q;
    assign buf_din  = buf_din_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign overrun  = overrun_q;
    assign count    = count_w;
    assign full     = full_w;
    assign empty    = empty_w;

`ifdef UART_RXC_IRQ_EN
    logic [ADDR_W:0] count_nxt;
    logic            irq_q, irq_d;

    // Use next-state occupancy so irq lines up with the registered count.
    always_comb begin
        count_nxt = count_w;
        if (wr_issue) begin
            count_nxt = count_w + (ADDR_W + 1)'(1);
        end else if (rd_start) begin
            count_nxt = count_w - (ADDR_W + 1)'(1);
        end
        irq_d = (count_nxt >= (ADDR_W + 1)'(IRQ_LEVEL)) || overrun_d;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
